// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake; multiply is an iterative
// shift-add that takes WIDTH cycles while busy is held high.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALU_ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALU_result,
  output logic             STL
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, MULT} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] acc_sum;

  // Single-cycle opcode results from the live operands
  always_comb begin
    single_res = '0;
    case (ALU_ctrl)
      4'b0000: single_res = ~(A | B);
      4'b0001: single_res = A + B;
      4'b0010: single_res = A;
      4'b0100: single_res = A - B;
      4'b0101: single_res = A & B;
      4'b0110: single_res = A | B;
      4'b0111: single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: single_res = '0;
    endcase
  end

  // Accumulator plus the current partial product
  always_comb begin
    acc_sum = acc + (mplier[0] ? mcand : '0);
  end

  // Handshake FSM, multiply datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ALU_result <= '0;
      STL        <= 1'b0;
      count      <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            STL <= (A < B);
            if (ALU_ctrl == 4'b0011) begin
              mcand  <= A;
              mplier <= B;
              acc    <= '0;
              count  <= '0;
              busy   <= 1'b1;
              state  <= MULT;
            end else begin
              ALU_result <= single_res;
              done       <= 1'b1;
            end
          end
        end
        MULT: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          // Last iteration: the final partial product goes straight to the result
          if (count == CW'(WIDTH - 1)) begin
            ALU_result <= acc_sum;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
